// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 target.
package spi_pkg;
  localparam int SPI_DATA_WIDTH = 8;

  typedef enum logic {IDLE, ACTIVE} spi_slave_state_t;

  typedef logic [SPI_DATA_WIDTH-1:0] spi_word_t;
endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser with single-cycle rise/fall pulses on the synced level.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // No reset: the chain keeps tracking the pin during reset, so a level
  // held across reset release never shows up as a spurious edge.
  always_ff @(posedge clock) begin
    sync_q <= {sync_q[STAGES-2:0], d_i};
    prev_q <= sync_q[STAGES-1];
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 target: oversampled sclk/mosi/nss, MSB-first, valid/ready on TX and RX.
// Optional build macro SPI_SLAVE_MISO_TRISTATE_EN releases miso to 'z' while idle.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  nss,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy,
  output logic                  overrun
);
  localparam int CW = $clog2(DATA_WIDTH);

  logic sclk_rise, sclk_fall, sclk_sync_unused;
  logic nss_s, nss_rise, nss_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
    .clock(clock), .d_i(sclk), .sync_o(sclk_sync_unused), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_nss (
    .clock(clock), .d_i(nss), .sync_o(nss_s), .rise_o(nss_rise), .fall_o(nss_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
    .clock(clock), .d_i(mosi), .sync_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused));

  spi_slave_state_t      state_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] rx_sh_q, tx_sh_q, tx_buf_q, rx_data_q;
  logic                  tx_full_q, rx_valid_q, overrun_q, busy_q, miso_q;
  logic [DATA_WIDTH-1:0] load_word;

  // An empty holding buffer at a word boundary sends zeros.
  assign load_word = tx_full_q ? tx_buf_q : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rx_sh_q    <= '0;
      tx_sh_q    <= '0;
      tx_buf_q   <= '0;
      rx_data_q  <= '0;
      tx_full_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      busy_q <= ~nss_s;
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (nss_fall) begin
            state_q   <= ACTIVE;
            cnt_q     <= '0;
            tx_sh_q   <= load_word;
            tx_full_q <= 1'b0;
            miso_q    <= load_word[DATA_WIDTH-1];
          end
        end
        ACTIVE: begin
          // nss edges take priority over any coincident sclk edge.
          if (nss_rise) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rx_sh_q <= '0;
            miso_q  <= 1'b0;
          end else if (sclk_rise) begin
            rx_sh_q <= {rx_sh_q[DATA_WIDTH-2:0], mosi_s};
            if (cnt_q == CW'(DATA_WIDTH-1)) begin
              cnt_q      <= '0;
              rx_data_q  <= {rx_sh_q[DATA_WIDTH-2:0], mosi_s};
              rx_valid_q <= 1'b1;
              if (rx_valid_q && !rx_ready) overrun_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (sclk_fall) begin
            if (cnt_q != '0) begin
              tx_sh_q <= tx_sh_q << 1;
              miso_q  <= tx_sh_q[DATA_WIDTH-2];
            end else begin
              tx_sh_q   <= load_word;
              tx_full_q <= 1'b0;
              miso_q    <= load_word[DATA_WIDTH-1];
            end
          end
        end
      endcase

      // Accept after any load above, so a word offered during an empty load waits.
      if (tx_valid && !tx_full_q) begin
        tx_buf_q  <= tx_data;
        tx_full_q <= 1'b1;
      end
    end
  end

  assign tx_ready = ~tx_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign miso = (state_q == ACTIVE) ? miso_q : 1'bz;
`else
  assign miso = miso_q;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// Scoreboarded bench for spi_slave: directed frames from the test plan plus random frames.
module tb_spi_slave;
  import spi_pkg::*;

  localparam int DW = 8;
  localparam int H  = 4;  // sclk half period in system clocks (clock/8)
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  localparam logic MISO_IDLE = 1'bz;
`else
  localparam logic MISO_IDLE = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          sclk = 1'b0, mosi = 1'b0, nss = 1'b1;
  logic          miso;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b1;
  logic          busy, overrun;

  int        checks = 0;
  int        errors = 0;
  spi_word_t exp_q[$];
  spi_word_t mw[4];
  spi_word_t tw[4];
  bit        off[4];

  spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .sclk(sclk), .mosi(mosi), .nss(nss), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .overrun(overrun));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_miso"},     32'(miso),     32'(MISO_IDLE));
    chk({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
    chk({tag, "_rx_data"},  32'(rx_data),  32'd0);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_overrun"},  32'(overrun),  32'd0);
  endtask

  // Offer a word on the TX handshake; bounded wait for tx_ready.
  task automatic offer(input spi_word_t d);
    int n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 20) begin
      clks(1);
      n++;
    end
    chk("tx_accept_ready", 32'(tx_ready), 32'd1);
    clks(1);
    tx_valid = 1'b0;
    chk("tx_ready_drop", 32'(tx_ready), 32'd0);
  endtask

  // Master model: nbits clocked from mw[]; word w on miso must equal tw[w] if
  // offered before its load, else zero. Completed RX words go to the scoreboard.
  task automatic frame(input int nbits, input bit push);
    spi_word_t got = '0;
    int nw = nbits / DW;
    if (off[0]) offer(tw[0]);
    nss = 1'b0;
    clks(2*H);
    chk("busy_in_frame", 32'(busy), 32'd1);
    chk("tx_ready_after_load", 32'(tx_ready), 32'd1);
    for (int i = 0; i < nbits; i++) begin
      int w = i / DW;
      int b = DW - 1 - (i % DW);
      mosi = mw[w][b];
      clks(H);
      sclk = 1'b1;
      got[b] = miso;
      if (b == 0 && w < nw) begin
        chk("miso_word", 32'(got), off[w] ? 32'(tw[w]) : 32'd0);
        if (push) exp_q.push_back(mw[w]);
      end
      if (b == 5 && w + 1 < nw && off[w+1]) offer(tw[w+1]);
      clks(H);
      sclk = 1'b0;
    end
    clks(H);
    nss = 1'b1;
    clks(2*H);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("miso_idle", 32'(miso), 32'(MISO_IDLE));
  endtask

  // Scoreboard monitor: every RX handshake must match the oldest expected word.
  always @(negedge clock) begin
    if (!reset && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got %0h expected none", rx_data);
      end else begin
        chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    clks(6);
    chk_reset_vals("rst");
    reset = 1'b0;
    clks(2);

    // Single frame
    mw = '{8'h3C, 8'h00, 8'h00, 8'h00};
    tw = '{8'hA5, 8'h00, 8'h00, 8'h00};
    off = '{1'b1, 1'b0, 1'b0, 1'b0};
    frame(8, 1'b1);

    // Back-to-back words
    mw = '{8'h12, 8'h34, 8'h00, 8'h00};
    tw = '{8'h81, 8'h7E, 8'h00, 8'h00};
    off = '{1'b1, 1'b1, 1'b0, 1'b0};
    frame(16, 1'b1);

    // TX underrun then late word
    mw = '{8'h9D, 8'h62, 8'h00, 8'h00};
    tw = '{8'h00, 8'h55, 8'h00, 8'h00};
    off = '{1'b0, 1'b1, 1'b0, 1'b0};
    frame(16, 1'b1);

    // Overrun: consumer stalled across two words
    rx_ready = 1'b0;
    mw = '{8'h11, 8'h22, 8'h00, 8'h00};
    off = '{1'b0, 1'b0, 1'b0, 1'b0};
    frame(16, 1'b0);
    chk("ovr_rx_data", 32'(rx_data), 32'h22);
    chk("ovr_rx_valid", 32'(rx_valid), 32'd1);
    chk("ovr_flag", 32'(overrun), 32'd1);
    exp_q.push_back(8'h22);
    @(posedge clock);
    #2 rx_ready = 1'b1;
    clks(3);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    chk("ovr_drained", 32'(rx_valid), 32'd0);
    reset = 1'b1;
    clks(4);
    reset = 1'b0;
    clks(2);
    chk("ovr_cleared", 32'(overrun), 32'd0);

    // Abort after 5 bits, then a clean frame
    mw = '{8'hE7, 8'h00, 8'h00, 8'h00};
    off = '{1'b0, 1'b0, 1'b0, 1'b0};
    frame(5, 1'b1);
    chk("abort_no_valid", 32'(rx_valid), 32'd0);
    mw = '{8'hF0, 8'h00, 8'h00, 8'h00};
    frame(8, 1'b1);

    // Reset mid-frame after 3 bits
    nss = 1'b0;
    clks(2*H);
    for (int i = 0; i < 3; i++) begin
      mosi = 1'($urandom);
      clks(H);
      sclk = 1'b1;
      clks(H);
      sclk = 1'b0;
    end
    reset = 1'b1;
    clks(4);
    chk_reset_vals("midrst");
    reset = 1'b0;
    clks(2);
    nss = 1'b1;
    clks(2*H);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_no_valid", 32'(rx_valid), 32'd0);
    mw = '{8'h5A, 8'h00, 8'h00, 8'h00};
    tw = '{8'hC3, 8'h00, 8'h00, 8'h00};
    off = '{1'b1, 1'b0, 1'b0, 1'b0};
    frame(8, 1'b1);

    // Random frames
    for (int f = 0; f < 20; f++) begin
      int nw = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) begin
        mw[i]  = spi_word_t'($urandom);
        tw[i]  = spi_word_t'($urandom);
        off[i] = ($urandom_range(0, 3) != 0);
      end
      frame(nw * DW, 1'b1);
    end

    for (int n = 0; n < 100 && exp_q.size() != 0; n++) clks(1);
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
